// File: rtl/demux_1_4_stream_pkg.sv
// Shared lane geometry and types for the 1-to-4 stream demultiplexer.
package demux_1_4_stream_pkg;

    localparam int unsigned N_LANES = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef logic [SEL_W-1:0] lane_sel_t;
    typedef logic [CNT_W-1:0] lane_cnt_t;

endpackage

// File: rtl/stream_slot.sv
// Single-entry output register for one demux lane: write wins over drain,
// so a lane can be refilled on the same edge it empties.
module stream_slot #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [WIDTH-1:0] data,
    input  logic             rd_ready
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr_en) begin
            full_d = 1'b1;
            data_d = wr_data;
        end else if (full_q && rd_ready) begin
            // Data is deliberately left in place after a drain.
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a single-entry register per lane.
// Optional per-lane drain counters on lane_cnt when DEMUX_1_4_STREAM_CNT_EN is defined.
module demux_1_4_stream
    import demux_1_4_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [1:0]       up_sel,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic [3:0]       down_valid,
    output logic [WIDTH-1:0] down_data0,
    output logic [WIDTH-1:0] down_data1,
    output logic [WIDTH-1:0] down_data2,
    output logic [WIDTH-1:0] down_data3,
    input  logic [3:0]       down_ready
`ifdef DEMUX_1_4_STREAM_CNT_EN
    ,
    output logic [31:0]      lane_cnt
`endif
);

    logic [N_LANES-1:0] full;
    logic [N_LANES-1:0] wr_en;
    logic [WIDTH-1:0]   lane_data [N_LANES];
    logic               accept;
    lane_sel_t          sel;

    assign sel = up_sel;

    // Only the addressed lane gates acceptance; other lanes may be stalled.
    always_comb begin
        up_ready = ~full[sel] | down_ready[sel];
    end

    assign accept = up_valid & up_ready;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        assign wr_en[i] = accept & (sel == lane_sel_t'(i));

        stream_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[i]),
            .wr_data  (up_data),
            .full     (full[i]),
            .data     (lane_data[i]),
            .rd_ready (down_ready[i])
        );
    end

    assign down_valid = full;
    assign down_data0 = lane_data[0];
    assign down_data1 = lane_data[1];
    assign down_data2 = lane_data[2];
    assign down_data3 = lane_data[3];

`ifdef DEMUX_1_4_STREAM_CNT_EN
    lane_cnt_t cnt_q [N_LANES];
    lane_cnt_t cnt_d [N_LANES];

    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (full[i] && down_ready[i]) begin
                cnt_d[i] = cnt_q[i] + lane_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign lane_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: directed scenarios plus a random
// run scored against per-lane in-flight queues.
module tb_demux_1_4_stream;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_valid;
    logic [1:0]   up_sel;
    logic [W-1:0] up_data;
    logic         up_ready;
    logic [3:0]   down_valid;
    logic [W-1:0] down_data0, down_data1, down_data2, down_data3;
    logic [3:0]   down_ready;
`ifdef DEMUX_1_4_STREAM_CNT_EN
    logic [31:0]  lane_cnt;
`endif

    logic [W-1:0] dd [4];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign dd[0] = down_data0;
    assign dd[1] = down_data1;
    assign dd[2] = down_data2;
    assign dd[3] = down_data3;

    demux_1_4_stream #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_sel     (up_sel),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data0 (down_data0),
        .down_data1 (down_data1),
        .down_data2 (down_data2),
        .down_data3 (down_data3),
        .down_ready (down_ready)
`ifdef DEMUX_1_4_STREAM_CNT_EN
        ,
        .lane_cnt   (lane_cnt)
`endif
    );

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d);
        up_valid = v;
        up_sel   = s;
        up_data  = d;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(1'b0, 2'd0, '0);
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        down_ready = 4'b0000;
        drive(1'b1, 2'd2, 4'h5);
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (down_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0000", down_valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dd[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_data%0d: got %h want 0", i, dd[i]);
            end
        end
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 2'd2, 4'h0);
        @(negedge clk);
        n_checks++;
        if (down_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_no_accept: got %b want 0000", down_valid);
        end
        n_checks++;
        if (up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_up_ready: got %b want 1", up_ready);
        end
        next_cycle();
    endtask

    task automatic test_routing;
        do_reset();
        down_ready = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            if (j < 4) drive(1'b1, 2'(j), W'(j + 1));
            else       drive(1'b0, 2'd0, '0);
            @(negedge clk);
            n_checks++;
            if (up_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL routing_ready%0d: got %b want 1", j, up_ready);
            end
            n_checks++;
            if (down_valid !== ((j == 0) ? 4'b0000 : 4'(1 << (j - 1)))) begin
                n_fail++;
                $display("FAIL routing_valid%0d: got %b want %b", j, down_valid,
                         (j == 0) ? 4'b0000 : 4'(1 << (j - 1)));
            end
            if (j > 0) begin
                n_checks++;
                if (dd[j-1] !== W'(j)) begin
                    n_fail++;
                    $display("FAIL routing_data%0d: got %h want %h", j - 1, dd[j-1], W'(j));
                end
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (down_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL routing_pulse: got %b want 0000", down_valid);
        end
        next_cycle();
    endtask

    task automatic test_backpressure;
        do_reset();
        down_ready = 4'b1110;
        drive(1'b1, 2'd0, 4'hA);
        @(negedge clk);
        n_checks++;
        if (up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_ready: got %b want 1", up_ready);
        end
        next_cycle();
        drive(1'b1, 2'd0, 4'hB);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (up_ready !== 1'b0 || down_valid !== 4'b0001 || dd[0] !== 4'hA) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got rdy=%b valid=%b d0=%h want rdy=0 valid=0001 d0=a",
                         k, up_ready, down_valid, dd[0]);
            end
            next_cycle();
        end
        down_ready = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", up_ready);
        end
        next_cycle();
        drive(1'b1, 2'd1, 4'hC);
        @(negedge clk);
        n_checks++;
        if (down_valid !== 4'b0001 || dd[0] !== 4'hB) begin
            n_fail++;
            $display("FAIL bp_second_word: got valid=%b d0=%h want valid=0001 d0=b",
                     down_valid, dd[0]);
        end
        next_cycle();
        drive(1'b0, 2'd0, '0);
        @(negedge clk);
        n_checks++;
        if (down_valid !== 4'b0010 || dd[1] !== 4'hC) begin
            n_fail++;
            $display("FAIL bp_lane1: got valid=%b d1=%h want valid=0010 d1=c",
                     down_valid, dd[1]);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        do_reset();
        down_ready = 4'b0100;
        for (int k = 0; k < 17; k++) begin
            if (k < 16) drive(1'b1, 2'd2, W'(k));
            else        drive(1'b0, 2'd0, '0);
            @(negedge clk);
            if (k < 16) begin
                n_checks++;
                if (up_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready%0d: got %b want 1", k, up_ready);
                end
            end
            if (k > 0) begin
                n_checks++;
                if (down_valid !== 4'b0100 || dd[2] !== W'(k - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: got valid=%b d2=%h want valid=0100 d2=%h",
                             k, down_valid, dd[2], W'(k - 1));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        down_ready = 4'b0000;
        drive(1'b1, 2'd0, 4'h5);
        next_cycle();
        drive(1'b1, 2'd3, 4'h9);
        next_cycle();
        drive(1'b0, 2'd0, '0);
        @(negedge clk);
        n_checks++;
        if (down_valid !== 4'b1001) begin
            n_fail++;
            $display("FAIL midrst_pre: got %b want 1001", down_valid);
        end
        rst = 1'b1;
        drive(1'b1, 2'd1, 4'h7);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 2'd0, '0);
        down_ready = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (down_valid !== 4'b0000) begin
                n_fail++;
                $display("FAIL midrst_post%0d: got %b want 0000", k, down_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_random;
        logic [W-1:0] infl [4][$];
        logic         pend = 1'b0;
        logic [1:0]   ps   = 2'd0;
        logic [W-1:0] pdat = '0;
        logic         exp_rdy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                ps   = 2'($urandom_range(0, 3));
                pdat = W'($urandom_range(0, 15));
            end
            drive(pend, ps, pdat);
            down_ready = 4'($urandom);
            @(negedge clk);
            exp_rdy = (infl[ps].size() == 0) || down_ready[ps];
            n_checks++;
            if (up_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_ready c%0d: got %b want %b", c, up_ready, exp_rdy);
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (down_valid[i] !== (infl[i].size() != 0)) begin
                    n_fail++;
                    $display("FAIL rand_valid c%0d lane%0d: got %b want %b", c, i,
                             down_valid[i], infl[i].size() != 0);
                end else if (infl[i].size() != 0 && dd[i] !== infl[i][0]) begin
                    n_fail++;
                    $display("FAIL rand_data c%0d lane%0d: got %h want %h", c, i,
                             dd[i], infl[i][0]);
                end
            end
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (infl[i].size() != 0 && down_ready[i]) void'(infl[i].pop_front());
            end
            if (pend && exp_rdy) begin
                infl[ps].push_back(pdat);
                pend = 1'b0;
            end
            #1;
        end
        drive(1'b0, 2'd0, '0);
    endtask

`ifdef DEMUX_1_4_STREAM_CNT_EN
    task automatic test_counter;
        do_reset();
        down_ready = 4'b1111;
        for (int k = 0; k < 257; k++) begin
            drive(1'b1, 2'd1, W'(k));
            next_cycle();
        end
        drive(1'b0, 2'd0, '0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (lane_cnt !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL lane_cnt: got %h want 00000100", lane_cnt);
        end
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef DEMUX_1_4_STREAM_CNT_EN
        test_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
